// File: rtl/port_int_arbiter_pkg.sv
// Shared constants for the GPIO port interrupt arbiter: state encoding,
// default port vector addresses and the port-index-to-vector helper.
// Pure declarations; no logic of its own.
package port_int_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2,
    GAP     = 2'd3
  } arb_state_t;

  localparam logic [15:0] VEC_PORT0 = 16'hFFDE;
  localparam logic [15:0] VEC_PORT1 = 16'hFFDC;
  localparam logic [15:0] VEC_PORT2 = 16'hFFDA;
  localparam logic [15:0] VEC_PORT3 = 16'hFFD8;
  localparam logic [15:0] VEC_PORT4 = 16'hFFD6;

  // Vector of port k: base minus 2*k, 16-bit unsigned wrap-around arithmetic.
  function automatic logic [15:0] port_vec(input logic [15:0] base, input logic [7:0] k);
    return base - {7'b0, k, 1'b0};
  endfunction

endpackage

// File: rtl/port_int_arbiter_prio_enc.sv
// Lowest-index-first priority encoder over the port request lines.
// Purely combinational, zero latency.
// No flow control; outputs follow the inputs every cycle.
module port_int_arbiter_prio_enc #(
  parameter int NPORTS = 8,
  parameter int IDW    = 3
) (
  input  logic [NPORTS-1:0] req,
  output logic              valid,
  output logic [IDW-1:0]    idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = i[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/port_int_arbiter.sv
// Fixed-priority arbiter from GPIO port interrupt lines to one CPU IRQ + vector.
// Request to IRQ is one cycle; selection is held through INTACK..RETI.
// Re-arbitrates only in IDLE/PEND; SERVICE and the GAP cycle ignore requests.
module port_int_arbiter
  import port_int_arbiter_pkg::*;
#(
  parameter int          NPORTS   = 8,
  parameter logic [15:0] VEC_BASE = VEC_PORT0,
  parameter int          IDW      = 3
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic [NPORTS-1:0] INTreq,
  input  logic              GIE,
  input  logic              INTACK,
  input  logic              RETI,
  output logic              IRQ,
  output logic [15:0]       IVEC,
  output logic [IDW-1:0]    PORTID,
  output logic              BUSY
);

  arb_state_t     state_q, state_d;
  logic           irq_q, irq_d;
  logic [15:0]    ivec_q, ivec_d;
  logic [IDW-1:0] portid_q, portid_d;
  logic           busy_q, busy_d;

  logic           enc_valid;
  logic [IDW-1:0] enc_idx;
  logic [15:0]    enc_vec;

  port_int_arbiter_prio_enc #(
    .NPORTS(NPORTS),
    .IDW   (IDW)
  ) u_prio_enc (
    .req  (INTreq),
    .valid(enc_valid),
    .idx  (enc_idx)
  );

  assign enc_vec = port_vec(VEC_BASE, 8'(enc_idx));

  // Next-state and output register values; INTACK in PEND takes precedence
  // over both a winner change and a GIE drop so the acked vector is frozen.
  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    ivec_d   = ivec_q;
    portid_d = portid_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (GIE && enc_valid) begin
          portid_d = enc_idx;
          ivec_d   = enc_vec;
          irq_d    = 1'b1;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (INTACK) begin
          irq_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = SERVICE;
        end else if (!GIE || !enc_valid) begin
          irq_d   = 1'b0;
          ivec_d  = 16'h0000;
          state_d = IDLE;
        end else begin
          portid_d = enc_idx;
          ivec_d   = enc_vec;
        end
      end
      SERVICE: begin
        if (RETI) begin
          busy_d  = 1'b0;
          ivec_d  = 16'h0000;
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      ivec_q   <= 16'h0000;
      portid_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      ivec_q   <= ivec_d;
      portid_q <= portid_d;
      busy_q   <= busy_d;
    end
  end

  assign IRQ    = irq_q;
  assign IVEC   = ivec_q;
  assign PORTID = portid_q;
  assign BUSY   = busy_q;

endmodule

// File: doc/port_int_arbiter.md
Name: port_int_arbiter

Overview:
- Fixed-priority interrupt arbiter between the GPIO port interrupt lines (PxINT/PyINT of every GPIO16 instance) and the CPU interrupt entry logic.
- Selects one pending port, raises a single IRQ with its vector address, and holds that selection through the CPU accept/return handshake.
- Re-arbitrates only when no service is in progress.
- Sits between the GPIO16 instances and the CPU state machine, alongside the other peripheral vector sources.

Parameters:
- NPORTS, 8, number of port interrupt inputs. Index 0 is highest priority. Legal range 1..8.
- VEC_BASE, 16'hFFDE, vector address of port index 0. Port k vector = VEC_BASE - 2*k.
- IDW, 3, width of the port ID output. Must satisfy 2^IDW >= NPORTS.

Ports:
- MCLK  in  1  system clock
- reset  in  1  reset
- INTreq  in  NPORTS  level interrupt requests, bit k = PkINT from GPIO16
- GIE  in  1  CPU status-register global interrupt enable
- INTACK  in  1  one-cycle pulse; CPU has begun interrupt entry for the presented vector
- RETI  in  1  one-cycle pulse; CPU executed RETI
- IRQ  out  1  interrupt request to CPU
- IVEC  out  16  vector address of the selected port; 16'h0000 when no selection
- PORTID  out  IDW  index of the selected/serviced port
- BUSY  out  1  high while a port interrupt is in service

Interface: reset is synchronous and active-high; clock is MCLK. Every register updates on posedge MCLK only.

Behaviour:
Reset values:
- State = IDLE; IRQ = 0; IVEC = 16'h0000; PORTID = 0; BUSY = 0.

IDLE:
- Condition: GIE & |INTreq.
- Registered action: latch the lowest set index k into PORTID; IVEC = VEC_BASE - 2*k; IRQ = 1; go to PEND.
- Latency: request to IRQ high is exactly 1 cycle.

PEND:
- Each cycle, re-run the priority encoder on INTreq.
- If the winner changes (higher-priority arrival, or the current request withdrawn while another is pending), update PORTID and IVEC that cycle; IRQ stays 1.
- If INTreq == 0 or GIE == 0: IRQ = 0, IVEC = 0, go to IDLE. No ack can follow.
- If INTACK: IRQ = 0, BUSY = 1, go to SERVICE. PORTID/IVEC freeze at the values presented in the cycle INTACK was sampled.
- Simultaneous INTACK and winner change: INTACK wins, and the frozen vector is the one presented (pre-update).
- Simultaneous INTACK and GIE = 0: INTACK wins.

SERVICE:
- Ignores INTreq and GIE.
- On RETI: BUSY = 0, IVEC = 0, go to GAP.
- INTACK in SERVICE is ignored; no nesting is supported.

GAP:
- One-cycle dead state, so the GPIO16 IV-read flag clear is visible before the next arbitration.
- Always goes to IDLE.

Boundaries:
- RETI outside SERVICE is ignored.
- INTreq bits at index >= NPORTS are absent by construction.
- A request held continuously is re-served after GAP (level-sensitive; the flag is cleared only by the IV read or software).
- Reset asserted in any state returns to the reset values next edge, including mid-SERVICE. No pending state is retained.

Widths:
- Vector arithmetic is 16-bit unsigned; k is zero-extended and shifted left by 1.

Decomposition:
- Shared include (global parameter file):
  - vector address constants (VEC_PORT1..VEC_PORT4, etc.)
  - state encodings: IDLE = 2'd0, PEND = 2'd1, SERVICE = 2'd2, GAP = 2'd3
- Sub-module prio_enc (parameterised NPORTS/IDW): combinational lowest-index-first encoder with outputs valid and idx.
- All state/registers remain in port_int_arbiter.

Test Plan:
- Reset sequence; GIE=1, INTreq=8'h04 -> next cycle IRQ=1, PORTID=2, IVEC=16'hFFDA; hold 5 cycles, outputs stable.
- In PEND with INTreq=8'h04, raise INTreq=8'h05 -> next cycle PORTID=0, IVEC=16'hFFDE, IRQ stays 1; pulse INTACK -> IRQ=0, BUSY=1, IVEC stays 16'hFFDE.
- In SERVICE, INTreq=8'hFF and GIE toggled -> no change; RETI pulse -> BUSY=0 next cycle; GAP 1 cycle; then IRQ=1 with PORTID=0 if bit0 still set.
- GIE=0 with INTreq=8'h80 -> IRQ stays 0 indefinitely; set GIE=1 -> IRQ=1, IVEC=16'hFFD0 after 1 cycle; drop INTreq before ack -> IRQ=0, state IDLE.
- Same-cycle INTACK and higher-priority arrival (8'h10 -> 8'h11) -> serviced vector remains 16'hFFD6, PORTID=4.
- Assert reset mid-SERVICE -> IRQ=0, BUSY=0, IVEC=0, PORTID=0 next edge; stray RETI/INTACK pulses in IDLE -> no effect.
